// File: rtl/tstack_pkg.sv
// tstack_pkg: shared op codes and pointer-width helpers for the cached-TOS stack.
package tstack_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        PICK = 3'd3,
        REPL = 3'd4,
        CLR  = 3'd5
    } tstack_op_e;

    localparam int DEF_DEPTH = 64;
    localparam int DEF_DSZ   = 32;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_SSZ = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/tstack_if.sv
// tstack_if: op/data request from the core decoder and stack status back to it.
interface tstack_if
    import tstack_pkg::*;
#(
    parameter int DSZ = DEF_DSZ,
    parameter int SSZ = DEF_SSZ
);
    logic           en;
    tstack_op_e     op;
    logic [DSZ-1:0] vi;
    logic [SSZ-1:0] idx;
    logic [DSZ-1:0] tos;
    logic [DSZ-1:0] nos;
    logic [DSZ-1:0] pick_q;
    logic           pick_v;
    logic [SSZ:0]   depth;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           unf;

    modport master (
        output en, op, vi, idx,
        input  tos, nos, pick_q, pick_v, depth, empty, full, ovf, unf
    );

    modport slave (
        input  en, op, vi, idx,
        output tos, nos, pick_q, pick_v, depth, empty, full, ovf, unf
    );

endinterface

// File: rtl/tstack_ram.sv
// tstack_ram: unreset register array, one synchronous write port and two async read ports.
module tstack_ram #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [SSZ-1:0] wa,
    input  logic [DSZ-1:0] wd,
    input  logic [SSZ-1:0] ra0,
    output logic [DSZ-1:0] rd0,
    input  logic [SSZ-1:0] ra1,
    output logic [DSZ-1:0] rd1
);

    logic [DSZ-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/tstack.sv
// tstack: data/return stack with TOS held in a register and NOS/PICK read from the array.
// Depth tracking, sticky ovf/unf, optional ring mode that drops the oldest entry on overflow.
module tstack
    import tstack_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DSZ   = DEF_DSZ,
    parameter int SSZ   = ptr_w(DEPTH),
    parameter int WRAP  = 0
) (
    input logic     clk,
    input logic     rst,
    tstack_if.slave bus
);

    localparam logic [SSZ:0]   DMAX = (SSZ+1)'(DEPTH);
    localparam logic [SSZ:0]   D1   = (SSZ+1)'(1);
    localparam logic [SSZ-1:0] P1   = SSZ'(1);

    logic [SSZ-1:0] sp, sp_n, nos_a, pick_a;
    logic [SSZ:0]   depth, depth_n;
    logic [DSZ-1:0] tos, tos_n, pick_q, pick_q_n, rd_nos, rd_pick;
    logic           ovf, ovf_n, unf, unf_n, pick_v, we, full, has2, in_rng;

    assign full   = depth == DMAX;
    assign has2   = depth > D1;
    assign in_rng = {1'b0, bus.idx} < depth;
    assign nos_a  = sp - P1;
    assign pick_a = sp - bus.idx;

    tstack_ram #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ)) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (sp),
        .wd  (tos),
        .ra0 (nos_a),
        .rd0 (rd_nos),
        .ra1 (pick_a),
        .rd1 (rd_pick)
    );

    always_comb begin
        tos_n    = tos;
        sp_n     = sp;
        depth_n  = depth;
        ovf_n    = ovf;
        unf_n    = unf;
        pick_q_n = pick_q;
        we       = 1'b0;
        if (bus.en)
            case (bus.op)
                PUSH:
                    if (!full || WRAP != 0) begin
                        we      = depth != '0;
                        sp_n    = we ? sp + P1 : sp;
                        tos_n   = bus.vi;
                        depth_n = full ? depth : depth + D1;
                    end else ovf_n = 1'b1;
                POP:
                    if (depth == '0) unf_n = 1'b1;
                    else begin
                        tos_n   = has2 ? rd_nos : '0;
                        sp_n    = has2 ? sp - P1 : sp;
                        depth_n = depth - D1;
                    end
                PICK: begin
                    pick_q_n = !in_rng ? '0 : bus.idx == '0 ? tos : rd_pick;
                    unf_n    = unf | !in_rng;
                end
                REPL: begin
                    tos_n   = bus.vi;
                    depth_n = depth == '0 ? D1 : depth;
                end
                CLR: begin
                    tos_n   = '0;
                    sp_n    = '0;
                    depth_n = '0;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                end
                default: ;
            endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tos    <= '0;
            sp     <= '0;
            depth  <= '0;
            pick_q <= '0;
            pick_v <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            tos    <= tos_n;
            sp     <= sp_n;
            depth  <= depth_n;
            pick_q <= pick_q_n;
            pick_v <= bus.en && bus.op == PICK;
            ovf    <= ovf_n;
            unf    <= unf_n;
        end

    assign bus.tos    = tos;
    assign bus.nos    = has2 ? rd_nos : '0;
    assign bus.pick_q = pick_q;
    assign bus.pick_v = pick_v;
    assign bus.depth  = depth;
    assign bus.empty  = depth == '0;
    assign bus.full   = full;
    assign bus.ovf    = ovf;
    assign bus.unf    = unf;

endmodule

// File: tb/tb_tstack.sv
// tb_tstack: saturating and ring DEPTH=4 stacks driven in lockstep against a list model.
module tb_tstack;
    import tstack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tstack_if #(.DSZ(32), .SSZ(2)) b0 ();
    tstack_if #(.DSZ(32), .SSZ(2)) b1 ();

    tstack #(.DEPTH(4), .DSZ(32), .WRAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    tstack #(.DEPTH(4), .DSZ(32), .WRAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    // model: ms[k][0] is the oldest entry, ms[k][mn[k]-1] is TOS
    logic [31:0] ms [2][4];
    int          mn [2];
    logic        m_ovf [2], m_unf [2], m_pv [2];
    logic [31:0] m_pq [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_pv[k] = 0; m_pq[k] = '0;
        end
    endtask

    task automatic m_step(input int k, input logic e, input tstack_op_e o,
                          input logic [31:0] v, input logic [1:0] i);
        m_pv[k] = e && o == PICK;
        if (e)
            case (o)
                PUSH:
                    if (mn[k] < 4) begin
                        ms[k][mn[k]] = v;
                        mn[k]++;
                    end else if (k == 1) begin
                        for (int j = 0; j < 3; j++) ms[k][j] = ms[k][j+1];
                        ms[k][3] = v;
                    end else m_ovf[k] = 1;
                POP:
                    if (mn[k] == 0) m_unf[k] = 1;
                    else mn[k]--;
                PICK:
                    if (int'(i) < mn[k]) m_pq[k] = ms[k][mn[k]-1-int'(i)];
                    else begin
                        m_pq[k]  = '0;
                        m_unf[k] = 1;
                    end
                REPL:
                    if (mn[k] == 0) begin
                        ms[k][0] = v;
                        mn[k] = 1;
                    end else ms[k][mn[k]-1] = v;
                CLR: begin
                    mn[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
                end
                default: ;
            endcase
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e_tos, e_nos, g_tos, g_nos, g_pq;
            logic [2:0]  g_dep;
            logic [4:0]  g_fl, e_fl;
            e_tos = mn[k] > 0 ? ms[k][mn[k]-1] : '0;
            e_nos = mn[k] > 1 ? ms[k][mn[k]-2] : '0;
            e_fl  = {mn[k] == 0, mn[k] == 4, m_ovf[k], m_unf[k], m_pv[k]};
            g_tos = k == 0 ? b0.tos : b1.tos;
            g_nos = k == 0 ? b0.nos : b1.nos;
            g_pq  = k == 0 ? b0.pick_q : b1.pick_q;
            g_dep = k == 0 ? b0.depth : b1.depth;
            g_fl  = k == 0 ? {b0.empty, b0.full, b0.ovf, b0.unf, b0.pick_v}
                           : {b1.empty, b1.full, b1.ovf, b1.unf, b1.pick_v};
            chk($sformatf("u%0d tos", k), 64'(g_tos), 64'(e_tos));
            chk($sformatf("u%0d nos", k), 64'(g_nos), 64'(e_nos));
            chk($sformatf("u%0d depth", k), 64'(g_dep), 64'(mn[k]));
            chk($sformatf("u%0d flags(empty,full,ovf,unf,pick_v)", k), 64'(g_fl), 64'(e_fl));
            chk($sformatf("u%0d pick_q", k), 64'(g_pq), 64'(m_pq[k]));
        end
    endtask

    task automatic drive(input logic e, input tstack_op_e o, input logic [31:0] v, input logic [1:0] i);
        b0.en = e; b0.op = o; b0.vi = v; b0.idx = i;
        b1.en = e; b1.op = o; b1.vi = v; b1.idx = i;
    endtask

    task automatic cyc(input logic e, input tstack_op_e o, input logic [31:0] v, input logic [1:0] i);
        drive(e, o, v, i);
        @(posedge clk);
        for (int k = 0; k < 2; k++) m_step(k, e, o, v, i);
        #1 cmp_all();
    endtask

    initial begin
        drive(1'b0, NOP, '0, '0);
        m_reset();
        #1 cmp_all();
        #5 rst = 1'b1;
        // basic push/pop
        cyc(1, PUSH, 32'h11, 0); cyc(1, PUSH, 32'h22, 0); cyc(1, PUSH, 32'h33, 0);
        chk("t1 tos", 64'(b0.tos), 64'h33);
        chk("t1 nos", 64'(b0.nos), 64'h22);
        repeat (3) cyc(1, POP, '0, 0);
        chk("t1 empty", 64'(b0.empty), 64'h1);
        // overflow: saturate vs ring
        for (int v = 1; v <= 5; v++) cyc(1, PUSH, 32'(v), 0);
        chk("t2 sat tos", 64'(b0.tos), 64'h4);
        chk("t2 sat ovf", 64'(b0.ovf), 64'h1);
        chk("t2 ring tos", 64'(b1.tos), 64'h5);
        chk("t2 ring ovf", 64'(b1.ovf), 64'h0);
        repeat (4) cyc(1, POP, '0, 0);
        cyc(1, CLR, '0, 0);
        for (int v = 1; v <= 6; v++) cyc(1, PUSH, 32'(v), 0);
        repeat (4) cyc(1, POP, '0, 0);
        chk("t3 ring empty", 64'(b1.empty), 64'h1);
        // PICK
        cyc(1, CLR, '0, 0);
        cyc(1, PUSH, 32'hA, 0); cyc(1, PUSH, 32'hB, 0); cyc(1, PUSH, 32'hC, 0);
        cyc(1, PICK, '0, 2);
        chk("t4 pick_q", 64'(b0.pick_q), 64'hA);
        cyc(1, PICK, '0, 1); cyc(1, PICK, '0, 0); cyc(1, PICK, '0, 3);
        cyc(1, NOP, '0, 0);
        // empty corner cases
        cyc(1, CLR, '0, 0); cyc(1, POP, '0, 0);
        cyc(1, REPL, 32'h55, 0); cyc(1, REPL, 32'h66, 0); cyc(1, CLR, '0, 0);
        // async reset during a push
        cyc(1, PUSH, 32'h7, 0); cyc(1, PUSH, 32'h8, 0);
        drive(1, PUSH, 32'h9, 0);
        #2 rst = 1'b0;
        m_reset();
        #1 cmp_all();
        chk("t6 reset tos", 64'(b0.tos), 64'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        cyc(1, POP, '0, 0);
        cyc(1, PUSH, 32'h3, 0);
        repeat (3) cyc(0, PUSH, 32'hDEAD, 0);
        cyc(0, PICK, '0, 0);
        // random traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            tstack_op_e o;
            r = int'($urandom_range(0, 15));
            o = r < 6 ? PUSH : r < 9 ? POP : r < 11 ? PICK : r == 11 ? REPL :
                r == 12 ? CLR : r == 13 ? NOP : tstack_op_e'(3'(r - 8));
            cyc($urandom_range(0, 4) != 0, o, $urandom, 2'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tstack.md
Name: tstack

Overview:
- Next-generation ForthSuper data/return stack with a cached top-of-stack.
- TOS sits in a register and NOS is readable combinationally, so Forth ALU ops read both operands in the same cycle.
- Adds depth tracking, full/empty status, sticky overflow/underflow errors, indexed PICK, in-place TOS replace, and an optional wrap (ring) mode that silently drops the oldest entry on overflow.
- Sits between the ForthSuper core's op decoder and its ALU, replacing the single-port stack.

Parameters:
- DEPTH, 64, total capacity including TOS; must be a power of 2 and at least 4.
- DSZ, 32, data width.
- SSZ, $clog2(DEPTH), pointer width.
- WRAP, 0, 0 = saturating (overflow is an error, PUSH ignored); 1 = ring (PUSH at full drops the oldest entry, no error).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  enable; when 0 no state changes and pick_v deasserts on the next edge.
- op  in  3  operation, tstack_op_e: NOP, PUSH, POP, PICK, REPL, CLR.
- vi  in  DSZ  push/replace data.
- idx  in  SSZ  PICK index; 0 = TOS, 1 = NOS.
- tos  out  DSZ  top of stack (register).
- nos  out  DSZ  next of stack (combinational read).
- pick_q  out  DSZ  PICK result (register).
- pick_v  out  1  pick_q valid strobe.
- depth  out  SSZ+1  entry count, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- ovf  out  1  sticky overflow error.
- unf  out  1  sticky underflow/range error.

Behaviour:
- Storage: TOS register plus an array mem[DEPTH] of DSZ bits, no reset on the array. The SSZ-bit write pointer sp wraps modulo DEPTH. Entries below TOS occupy mem[sp-1] down to mem[sp-(depth-1)].
- Reset (rst=0, async): tos=0, sp=0, depth=0, pick_q=0, pick_v=0, ovf=0, unf=0. A reset mid-operation discards the op in flight.
- nos: mem[sp-1] when depth >= 2, else 0. Combinational from the current state.
- All updates occur on the rising clk edge with en=1, one op per cycle. Results are visible the next cycle, so back-to-back ops are allowed.
- NOP: no change.
- PUSH, depth < DEPTH:
  - If depth > 0: mem[sp] <= tos and sp <= sp+1.
  - Always: tos <= vi and depth <= depth+1.
- PUSH, depth == DEPTH:
  - WRAP=0: state unchanged, ovf <= 1.
  - WRAP=1: mem[sp] <= tos, sp <= sp+1, tos <= vi, depth stays DEPTH. The oldest entry (old mem[sp+1]) is logically lost.
- POP, depth >= 2: tos <= mem[sp-1], sp <= sp-1, depth <= depth-1.
- POP, depth == 1: tos <= 0, depth <= 0, sp unchanged.
- POP, depth == 0: no state change, unf <= 1.
- PICK:
  - No change to stack state. pick_v <= 1 on the next cycle (1-cycle latency).
  - pick_q <= tos if idx == 0; mem[sp-idx] if 0 < idx < depth.
  - If idx >= depth: pick_q <= 0 and unf <= 1.
  - pick_v is a single-cycle strobe; it is 0 after any non-PICK op.
- REPL: tos <= vi, no other change. If depth == 0: REPL acts as PUSH (depth becomes 1).
- CLR: depth <= 0, sp <= 0, tos <= 0, ovf <= 0, unf <= 0. The array is not cleared.
- Error flags: ovf and unf are sticky until CLR or reset. A flag set in the same cycle as CLR is not possible, since one op per cycle.
- Status: empty and full are combinational from depth.
- Width: sp arithmetic is modulo 2^SSZ. depth never exceeds DEPTH and never goes below 0.

Decomposition:
- Package tstack_pkg holds:
  - typedef enum logic [2:0] tstack_op_e {NOP=0, PUSH=1, POP=2, PICK=3, REPL=4, CLR=5}; codes 6–7 are treated as NOP.
  - Localparam helpers for pointer width.
- One natural sub-module, tstack_ram: a parametrised register-array memory with one synchronous write port and two combinational read ports (nos and pick). This keeps the array swappable for EBR later.
- The top level holds the TOS/sp/depth control logic.

Test Plan:
1. Reset, then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, depth=3, empty=0; then POP x3 -> tos/nos go 0x22/0x11, 0x11/0, then 0/0 with empty=1.
2. WRAP=0, DEPTH=4: PUSH 1..5 -> after the 4th PUSH full=1, tos=4; the 5th sets ovf=1 with tos=4 and depth=4 unchanged. POP x4 returns 4,3,2,1.
3. WRAP=1, DEPTH=4: PUSH 1..6 -> depth=4, ovf=0, tos=6; POP x3 yields tos 5,4,3, and a further POP leaves empty=1 (entries 1,2 lost).
4. PUSH 0xA,0xB,0xC; PICK idx=2 -> next cycle pick_v=1, pick_q=0xA; PICK idx=3 -> pick_q=0, unf=1; the stack is unchanged throughout.
5. POP on empty -> unf=1 and depth stays 0; REPL 0x55 on empty -> depth=1, tos=0x55; CLR -> unf=0, depth=0, tos=0.
6. PUSH 7, 8, then assert rst low asynchronously mid-cycle during a PUSH 9 -> all outputs 0 immediately. After release, POP sets unf=1; en=0 cycles hold state.
